// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } fetch_state_t;

  localparam logic [31:0] NOP_INST = 32'h0;
  localparam logic [31:0] PC_INC   = 32'd4;

  // Instruction addresses are word aligned; low two bits are discarded.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_perf_cnt.sv
// Delivered / discarded fetch-response counters, both wrapping modulo 2^32.
module if_perf_cnt
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc_i,
  input  logic        kill_inc_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] kill_cnt_o
);

  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] kill_cnt_q, kill_cnt_d;

  assign fetch_cnt_d = fetch_inc_i ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
  assign kill_cnt_d  = kill_inc_i  ? kill_cnt_q  + 32'd1 : kill_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign kill_cnt_o  = kill_cnt_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC, single-outstanding imem fetch, IF/ID output register.
// Define PERF_CNT_EN to instantiate the fetch/kill counters; otherwise they read as zero.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        flush,
  output logic [31:0] fetch_cnt,
  output logic [31:0] kill_cnt
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         valid_q, valid_d;
  logic         out_free;
  logic         load;
  logic [31:0]  target_pc;

  assign target_pc = align_pc(redirect_pc);
  // A request may only go out if its response is guaranteed an empty register.
  assign out_free  = !valid_q || !stall;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    imem_req = 1'b0;
    load     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d = target_pc;
        end else if (out_free) begin
          imem_req = 1'b1;
          req_pc_d = pc_q;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = IDLE;
          if (redirect) begin
            pc_d = target_pc;
          end else begin
            load = 1'b1;
            pc_d = pc_q + PC_INC;
          end
        end else if (redirect) begin
          pc_d    = target_pc;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (redirect)    pc_d    = target_pc;
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d  = valid_q;
    inst_d   = inst_q;
    pc_out_d = pc_out_q;
    if (redirect)                valid_d = 1'b0;
    else if (load)               valid_d = 1'b1;
    else if (valid_q && !stall)  valid_d = 1'b0;
    if (load) begin
      inst_d   = imem_rdata;
      pc_out_d = req_pc_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      valid_q  <= 1'b0;
      inst_q   <= NOP_INST;
      pc_out_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      valid_q  <= valid_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
    end
  end

  assign imem_addr = pc_q;
  assign valid_out = valid_q;
  assign inst_out  = inst_q;
  assign pc_out    = pc_out_q;
  assign flush     = redirect;

`ifdef PERF_CNT_EN
  logic kill;
  // A response is thrown away if it meets a redirect in WAIT or lands in DRAIN.
  assign kill = imem_rvalid && ((state_q == WAIT && redirect) || state_q == DRAIN);

  if_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .fetch_inc_i (load),
    .kill_inc_i  (kill),
    .fetch_cnt_o (fetch_cnt),
    .kill_cnt_o  (kill_cnt)
  );
`else
  assign fetch_cnt = 32'h0;
  assign kill_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: variable-latency imem model plus delivery scoreboard.
module tb_if_fetch_unit;

`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] DATA_OFS = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_rvalid, stall, redirect, valid_out, flush;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst_out, pc_out, fetch_cnt, kill_cnt;

  logic        w_req, w_rvalid, w_valid, w_flush, w_pend;
  logic        w_stall = 1'b0, w_redirect = 1'b0;
  logic [31:0] w_addr, w_rdata, w_inst, w_pc, w_fcnt, w_kcnt;
  logic [31:0] w_redirect_pc = 32'h0;
  logic [31:0] w_seen [2];
  int          w_n = 0;

  int          n_checks = 0, n_errors = 0;
  int          lat;
  logic [31:0] exp_q [$];
  logic [31:0] fetch_exp, kill_exp;

  typedef struct {
    int          lat;
    int          dly;
    logic [31:0] rpc;
    bit          twice;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .valid_out(valid_out),
    .inst_out(inst_out), .pc_out(pc_out), .flush(flush),
    .fetch_cnt(fetch_cnt), .kill_cnt(kill_cnt)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .stall(w_stall),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc), .valid_out(w_valid),
    .inst_out(w_inst), .pc_out(w_pc), .flush(w_flush),
    .fetch_cnt(w_fcnt), .kill_cnt(w_kcnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic drive_edge();
    @(posedge clk); #1;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 60; i++) begin
      sample();
      if (exp_q.size() == 0) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s: %0d deliveries pending, required 0", name, exp_q.size());
    exp_q.delete();
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 30; i++) begin
      if (imem_req) return;
      sample();
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s: imem_req stayed 0, required 1", name);
  endtask

  // imem model: fixed latency per request, data = address + DATA_OFS.
  int          m_cnt;
  bit          m_pend = 1'b0;
  logic [31:0] m_addr;
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
  end
  always @(negedge clk) begin
    if (rst) begin
      m_pend      = 1'b0;
      imem_rvalid = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      if (m_pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = m_addr + DATA_OFS;
          m_pend      = 1'b0;
        end
      end
      if (imem_req) begin
        m_pend = 1'b1;
        m_addr = imem_addr;
        m_cnt  = lat;
      end
    end
  end

  // 1-cycle responder for the wrap instance; records its first two fetch addresses.
  initial begin
    w_pend   = 1'b0;
    w_rvalid = 1'b0;
    w_rdata  = 32'h0;
  end
  always @(negedge clk) begin
    w_rvalid = w_pend && !rst;
    w_rdata  = 32'h1234_5678;
    w_pend   = w_req && !rst;
    if (!rst && w_req && w_n < 2) begin
      w_seen[w_n] = w_addr;
      w_n++;
    end
  end

  // Scoreboard: each newly loaded instruction must match the head of exp_q.
  bit          prev_valid = 1'b0, prev_stall = 1'b0;
  logic [31:0] e;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (valid_out && !(prev_valid && prev_stall)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL deliv_unexpected: got pc_out=%h, required no delivery", pc_out);
        end else begin
          e = exp_q.pop_front();
          check("deliv_pc", pc_out, e);
          check("deliv_inst", inst_out, e + DATA_OFS);
        end
      end
      prev_valid = valid_out;
      prev_stall = stall;
    end
  end

  initial begin
    vecs[0] = '{lat: 3, dly: 1, rpc: 32'h0000_0200, twice: 1'b0, exp_addr: 32'h0000_0200};
    vecs[1] = '{lat: 1, dly: 1, rpc: 32'h0000_0203, twice: 1'b0, exp_addr: 32'h0000_0200};
    vecs[2] = '{lat: 3, dly: 3, rpc: 32'h0000_03FF, twice: 1'b0, exp_addr: 32'h0000_03FC};
    vecs[3] = '{lat: 4, dly: 2, rpc: 32'h0000_1000, twice: 1'b0, exp_addr: 32'h0000_1000};
    vecs[4] = '{lat: 4, dly: 1, rpc: 32'h0000_0500, twice: 1'b1, exp_addr: 32'h0000_0600};

    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    lat         = 1;
    fetch_exp   = 32'h0;
    kill_exp    = 32'h0;

    repeat (2) @(posedge clk);
    sample();
    check("rst_valid", valid_out, 0);
    check("rst_inst", inst_out, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_fetch_cnt", fetch_cnt, 32'h0);
    check("rst_kill_cnt", kill_cnt, 32'h0);

    // Sequential fetch with 1-cycle memory.
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    fetch_exp = 3;
    drive_edge();
    rst = 1'b0;
    sample();
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h100);
    for (int i = 0; i < 10 && !valid_out; i++) sample();
    for (int k = 1; k <= 4; k++) begin
      sample();
      check("valid_alternates", valid_out, (k % 2 == 0) ? 1 : 0);
    end
    check("seq_pending", exp_q.size(), 0);

    // Hold stall for 5 cycles on the next delivery.
    exp_q.push_back(32'h10C);
    fetch_exp++;
    for (int i = 0; i < 10; i++) begin
      drive_edge();
      if (valid_out) begin
        stall = 1'b1;
        break;
      end
    end
    for (int i = 0; i < 5; i++) begin
      sample();
      check("stall_valid", valid_out, 1);
      check("stall_pc", pc_out, 32'h10C);
      check("stall_inst", inst_out, 32'h10C + DATA_OFS);
      check("stall_no_req", imem_req, 0);
      drive_edge();
    end
    exp_q.push_back(32'h110);
    fetch_exp++;
    stall = 1'b0;
    sample();
    check("unstall_req", imem_req, 1);
    check("unstall_addr", imem_addr, 32'h110);

    // Redirect scenarios: in WAIT, coincident with rvalid, and double redirect in DRAIN.
    for (int i = 0; i < 5; i++) begin
      lat = vecs[i].lat;
      wait_empty("pre_redirect_delivery");
      check("redirect_setup_req", imem_req, 1);
      repeat (vecs[i].dly) @(posedge clk);
      #1;
      redirect    = 1'b1;
      redirect_pc = vecs[i].rpc;
      exp_q.push_back(vecs[i].exp_addr);
      fetch_exp++;
      kill_exp++;
      sample();
      check("flush", flush, 1);
      drive_edge();
      if (vecs[i].twice) begin
        redirect_pc = vecs[i].rpc + 32'h100;
        sample();
        check("flush_again", flush, 1);
        drive_edge();
      end
      redirect = 1'b0;
      sample();
      check("valid_after_redirect", valid_out, 0);
      wait_req("post_redirect_req");
      check("redirect_addr", imem_addr, vecs[i].exp_addr);
      check("kill_cnt", kill_cnt, PERF ? kill_exp : 32'h0);
    end

    // Reset asserted while a 3-cycle fetch is outstanding.
    lat = 3;
    wait_empty("pre_reset_delivery");
    check("fetch_cnt", fetch_cnt, PERF ? fetch_exp : 32'h0);
    drive_edge();
    rst = 1'b1;
    #1;
    check("midwait_rst_valid", valid_out, 0);
    check("midwait_rst_inst", inst_out, 32'h0);
    check("midwait_rst_pc_out", pc_out, 32'h0);
    check("midwait_rst_fetch_cnt", fetch_cnt, 32'h0);
    check("midwait_rst_kill_cnt", kill_cnt, 32'h0);
    exp_q.delete();
    fetch_exp = 0;
    kill_exp  = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(32'h100);
    fetch_exp = 1;
    sample();
    check("post_rst_req", imem_req, 1);
    check("post_rst_addr", imem_addr, 32'h100);
    wait_empty("post_reset_delivery");
    check("post_rst_fetch_cnt", fetch_cnt, PERF ? fetch_exp : 32'h0);
    check("post_rst_kill_cnt", kill_cnt, 32'h0);

    // PC wrap on the second instance.
    check("wrap_count", w_n, 2);
    check("wrap_first_addr", w_seen[0], 32'hFFFF_FFFC);
    check("wrap_second_addr", w_seen[1], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
